// File: rtl/sr_err_defs.sv
// Shared constants for the switch/display and CPU-error register block:
// iopage addresses, CER bit layout and the error-source index map.
package sr_err_defs;

  localparam logic [12:0] ADDR_SWR    = 13'o17570;
  localparam logic [12:0] ADDR_ERR_LO = 13'o17740;
  localparam logic [12:0] ADDR_ERR_HI = 13'o17742;
  localparam logic [12:0] ADDR_CER    = 13'o17766;

  localparam logic [11:0] WADDR_SWR    = ADDR_SWR[12:1];
  localparam logic [11:0] WADDR_ERR_LO = ADDR_ERR_LO[12:1];
  localparam logic [11:0] WADDR_ERR_HI = ADDR_ERR_HI[12:1];
  localparam logic [11:0] WADDR_CER    = ADDR_CER[12:1];

  localparam int CER_EVT_LSB = 2;
  localparam int CER_EVT_MAX = 6;

  typedef enum logic [2:0] {
    EVT_RED_STACK    = 3'd0,
    EVT_YELLOW_STACK = 3'd1,
    EVT_UNIBUS_TMO   = 3'd2,
    EVT_NXM          = 3'd3,
    EVT_ODD_ADDR     = 3'd4,
    EVT_ILL_HALT     = 3'd5
  } err_src_e;

  // CER read image: sources in bits 7:2, everything else reads zero.
  function automatic logic [15:0] cer_read(input logic [CER_EVT_MAX-1:0] bits);
    return {8'h00, bits, 2'b00};
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Console switch synchroniser and debouncer: a new value is accepted only
// after it has been seen unchanged for DEBOUNCE cycles past the synchroniser.
module sr_debounce #(
  parameter int W        = 16,
  parameter int DEBOUNCE = 1024
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] sample_o
);

  localparam int            CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [W-1:0]  sync1_q, sync2_q;
  logic [W-1:0]  cand_q, cand_d;
  logic [W-1:0]  sample_q, sample_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = {CW{1'b0}};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    // Re-loading while saturated is harmless: the candidate cannot change then.
    if (cnt_d == CNT_MAX) begin
      sample_d = cand_q;
    end else begin
      sample_d = sample_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q  <= {W{1'b0}};
      sync2_q  <= {W{1'b0}};
      cand_q   <= {W{1'b0}};
      cnt_q    <= {CW{1'b0}};
      sample_q <= {W{1'b0}};
    end else begin
      sync1_q  <= sw_i;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/sr_err_regs.sv
// PDP-11 iopage slave: debounced switch register, write-only display register,
// CPU error register with first-error physical address latch.
module sr_err_regs
  import sr_err_defs::*;
#(
  parameter int SW_WIDTH = 16,
  parameter int DEBOUNCE = 1024,
  parameter int N_ERR    = 6,
  parameter int AW       = 22
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [12:0]         iopage_addr,
  input  logic [15:0]         data_in,
  input  logic                iopage_rd,
  input  logic                iopage_wr,
  input  logic                iopage_byte_op,
  output logic [15:0]         data_out,
  output logic                decode,
  input  logic [SW_WIDTH-1:0] switches,
  output logic [SW_WIDTH-1:0] display,
  input  logic [N_ERR-1:0]    err_evt,
  input  logic [AW-1:0]       err_addr,
  output logic                err_pending
);

  logic [SW_WIDTH-1:0] switch_sample;
  logic [SW_WIDTH-1:0] display_q, display_d;
  logic [N_ERR-1:0]    cer_q, cer_d;
  logic [AW-1:0]       err_addr_q, err_addr_d;
  logic                addr_valid_q, addr_valid_d;

  logic [11:0] waddr;
  logic        hit_swr, hit_lo, hit_hi, hit_cer;
  logic        wr_swr, wr_cer, any_evt, valid_after_wr;
  logic [15:0] disp16, disp16_d;
  logic [N_ERR-1:0] cer_base;
  logic [31:0] ea32;
  logic        unused_rd;

  sr_debounce #(
    .W        (SW_WIDTH),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .sw_i     (switches),
    .sample_o (switch_sample)
  );

  assign waddr   = iopage_addr[12:1];
  assign hit_swr = (waddr == WADDR_SWR);
  assign hit_lo  = (waddr == WADDR_ERR_LO);
  assign hit_hi  = (waddr == WADDR_ERR_HI);
  assign hit_cer = (waddr == WADDR_CER);
  assign decode  = hit_swr | hit_lo | hit_hi | hit_cer;

  assign wr_swr  = iopage_wr & hit_swr;
  assign wr_cer  = iopage_wr & hit_cer;
  assign any_evt = |err_evt;
  assign disp16  = 16'(display_q);
  assign ea32    = 32'(err_addr_q);
  assign unused_rd = iopage_rd;

  // Display register: word or byte-lane update; odd byte lanes carry data in 15:8.
  always_comb begin
    disp16_d = disp16;
    if (wr_swr && !iopage_byte_op) begin
      disp16_d = data_in;
    end else if (wr_swr && iopage_addr[0]) begin
      disp16_d[15:8] = data_in[15:8];
    end else if (wr_swr) begin
      disp16_d[7:0] = data_in[7:0];
    end else begin
      disp16_d = disp16;
    end
    display_d = disp16_d[SW_WIDTH-1:0];
  end

  // CER and first-error latch; an event in the write cycle wins and re-arms the latch.
  always_comb begin
    cer_base       = wr_cer ? data_in[CER_EVT_LSB +: N_ERR] : cer_q;
    cer_d          = cer_base | err_evt;
    valid_after_wr = wr_cer ? 1'b0 : addr_valid_q;
    err_addr_d     = err_addr_q;
    addr_valid_d   = valid_after_wr;
    if (any_evt && !valid_after_wr) begin
      err_addr_d   = err_addr;
      addr_valid_d = 1'b1;
    end else begin
      err_addr_d   = err_addr_q;
      addr_valid_d = valid_after_wr | any_evt;
    end
  end

  // Register file state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      display_q    <= {SW_WIDTH{1'b0}};
      cer_q        <= {N_ERR{1'b0}};
      err_addr_q   <= {AW{1'b0}};
      addr_valid_q <= 1'b0;
    end else begin
      display_q    <= display_d;
      cer_q        <= cer_d;
      err_addr_q   <= err_addr_d;
      addr_valid_q <= addr_valid_d;
    end
  end

  // Read mux; undecoded addresses return zero so the iopage OR-mux is unaffected.
  always_comb begin
    data_out = 16'h0000;
    case (waddr)
      WADDR_SWR:    data_out = 16'(switch_sample);
      WADDR_ERR_LO: data_out = ea32[15:0];
      WADDR_ERR_HI: data_out = ea32[31:16];
      WADDR_CER:    data_out = cer_read(CER_EVT_MAX'(cer_q));
      default:      data_out = 16'h0000;
    endcase
  end

  assign display     = display_q;
  assign err_pending = |cer_q;

endmodule

// File: tb/tb_sr_err_regs.sv
// Directed bench for sr_err_regs: table of register-access vectors plus
// hand-written debounce, glitch and reset sequences.
module tb_sr_err_regs;
  import sr_err_defs::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] iopage_addr = 13'o0;
  logic [15:0] data_in = 16'h0000;
  logic        iopage_rd = 1'b0;
  logic        iopage_wr = 1'b0;
  logic        iopage_byte_op = 1'b0;
  logic [15:0] data_out;
  logic        decode;
  logic [15:0] switches = 16'h0000;
  logic [15:0] display;
  logic [5:0]  err_evt = 6'b0;
  logic [21:0] err_addr = 22'o0;
  logic        err_pending;

  int n_cmp = 0;
  int n_bad = 0;

  sr_err_regs #(
    .SW_WIDTH (16),
    .DEBOUNCE (8),
    .N_ERR    (6),
    .AW       (22)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .iopage_addr    (iopage_addr),
    .data_in        (data_in),
    .iopage_rd      (iopage_rd),
    .iopage_wr      (iopage_wr),
    .iopage_byte_op (iopage_byte_op),
    .data_out       (data_out),
    .decode         (decode),
    .switches       (switches),
    .display        (display),
    .err_evt        (err_evt),
    .err_addr       (err_addr),
    .err_pending    (err_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0o, expected %0o", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        bop;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic [5:0]  evt;
    logic [21:0] eaddr;
    logic [12:0] raddr;
    logic [15:0] exp_data;
    logic        exp_dec;
    logic        exp_pend;
    logic [15:0] exp_disp;
  } vec_t;

  vec_t vecs[19];

  // Waits up to 40 edges for the switch register to read 'target', optionally
  // injecting a one-cycle glitch after edge 'g'; checks the edge it appears on.
  task automatic wait_sample(input string name, input logic [15:0] target,
                             input logic [15:0] gval, input int g, input int exp_k);
    int found;
    logic [15:0] nv;
    found = 0;
    nv = switches;
    iopage_addr = ADDR_SWR;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (found == 0 && data_out == target) found = k;
      if (g > 0 && k == g) switches = gval;
      if (g > 0 && k == g + 1) switches = nv;
    end
    check(name, 32'(found), 32'(exp_k));
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 13'o0,   16'h0000,   6'b000000, 22'o0,        ADDR_CER,    16'o000000, 1'b1, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 13'o0,   16'h0000,   6'b000000, 22'o0,        ADDR_SWR,    16'o000000, 1'b1, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 13'o0,   16'h0000,   6'b000000, 22'o0,        13'o17700,   16'o000000, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, ADDR_SWR, 16'o177777, 6'b000000, 22'o0,       ADDR_CER,    16'o000000, 1'b1, 1'b0, 16'hFFFF};
    vecs[4]  = '{1'b1, 1'b1, 13'o17571, 16'h1212, 6'b000000, 22'o0,        ADDR_SWR,    16'o000000, 1'b1, 1'b0, 16'h12FF};
    vecs[5]  = '{1'b1, 1'b1, ADDR_SWR, 16'h3434,  6'b000000, 22'o0,        ADDR_SWR,    16'o000000, 1'b1, 1'b0, 16'h1234};
    vecs[6]  = '{1'b0, 1'b0, 13'o0,   16'h0000,   6'b000100, 22'o17765432, ADDR_CER,    16'o000020, 1'b1, 1'b1, 16'h1234};
    vecs[7]  = '{1'b0, 1'b0, 13'o0,   16'h0000,   6'b000000, 22'o0,        ADDR_ERR_LO, 16'o165432, 1'b1, 1'b1, 16'h1234};
    vecs[8]  = '{1'b0, 1'b0, 13'o0,   16'h0000,   6'b000000, 22'o0,        ADDR_ERR_HI, 16'o000077, 1'b1, 1'b1, 16'h1234};
    vecs[9]  = '{1'b0, 1'b0, 13'o0,   16'h0000,   6'b010000, 22'o01234567, ADDR_CER,    16'o000120, 1'b1, 1'b1, 16'h1234};
    vecs[10] = '{1'b0, 1'b0, 13'o0,   16'h0000,   6'b000000, 22'o0,        ADDR_ERR_LO, 16'o165432, 1'b1, 1'b1, 16'h1234};
    vecs[11] = '{1'b1, 1'b0, ADDR_ERR_LO, 16'hFFFF, 6'b000000, 22'o0,      ADDR_ERR_LO, 16'o165432, 1'b1, 1'b1, 16'h1234};
    vecs[12] = '{1'b1, 1'b0, ADDR_CER, 16'h0000,  6'b000001, 22'o00054321, ADDR_CER,    16'o000004, 1'b1, 1'b1, 16'h1234};
    vecs[13] = '{1'b0, 1'b0, 13'o0,   16'h0000,   6'b000000, 22'o0,        ADDR_ERR_LO, 16'o054321, 1'b1, 1'b1, 16'h1234};
    vecs[14] = '{1'b0, 1'b0, 13'o0,   16'h0000,   6'b000000, 22'o0,        ADDR_ERR_HI, 16'o000000, 1'b1, 1'b1, 16'h1234};
    vecs[15] = '{1'b1, 1'b0, ADDR_CER, 16'h0000,  6'b000000, 22'o0,        ADDR_CER,    16'o000000, 1'b1, 1'b0, 16'h1234};
    vecs[16] = '{1'b1, 1'b0, ADDR_CER, 16'o177777, 6'b000000, 22'o0,       ADDR_CER,    16'o000374, 1'b1, 1'b1, 16'h1234};
    vecs[17] = '{1'b1, 1'b1, 13'o17767, 16'h0000, 6'b000000, 22'o0,        ADDR_CER,    16'o000000, 1'b1, 1'b0, 16'h1234};
    vecs[18] = '{1'b0, 1'b0, 13'o0,   16'h0000,   6'b100000, 22'o00000777, ADDR_ERR_LO, 16'o000777, 1'b1, 1'b1, 16'h1234};

    // Reset state.
    iopage_addr = ADDR_CER;
    repeat (2) @(posedge clk);
    #1;
    check("reset_cer", 32'(data_out), 32'h0);
    check("reset_pend", 32'(err_pending), 32'h0);
    check("reset_disp", 32'(display), 32'h0);
    reset_n = 1'b1;

    // Register access table.
    iopage_rd = 1'b1;
    for (int i = 0; i < 19; i++) begin
      iopage_addr    = vecs[i].addr;
      iopage_wr      = vecs[i].wr;
      iopage_byte_op = vecs[i].bop;
      data_in        = vecs[i].wdata;
      err_evt        = vecs[i].evt;
      err_addr       = vecs[i].eaddr;
      @(posedge clk);
      #1;
      iopage_wr      = 1'b0;
      iopage_byte_op = 1'b0;
      err_evt        = 6'b0;
      iopage_addr    = vecs[i].raddr;
      #1;
      check($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_decode", i), 32'(decode), 32'(vecs[i].exp_dec));
      check($sformatf("vec%0d_pending", i), 32'(err_pending), 32'(vecs[i].exp_pend));
      check($sformatf("vec%0d_display", i), 32'(display), 32'(vecs[i].exp_disp));
    end

    // Debounce: steady change lands 2 + DEBOUNCE edges later.
    @(posedge clk);
    #1;
    switches = 16'o123456;
    wait_sample("debounce_steady", 16'o123456, 16'h0000, 0, 10);

    // Glitch after edge 5 restarts the count: lands on edge 16.
    @(posedge clk);
    #1;
    switches = 16'o070707;
    wait_sample("debounce_glitch", 16'o070707, 16'o111111, 5, 16);

    // Reset mid-debounce and mid-cycle.
    @(posedge clk);
    #1;
    switches = 16'o055555;
    repeat (5) @(posedge clk);
    #3;
    iopage_addr = ADDR_CER;
    reset_n = 1'b0;
    #1;
    check("midreset_cer", 32'(data_out), 32'h0);
    check("midreset_pend", 32'(err_pending), 32'h0);
    check("midreset_disp", 32'(display), 32'h0);
    iopage_addr = ADDR_SWR;
    #1;
    check("midreset_swr", 32'(data_out), 32'h0);
    iopage_addr = ADDR_ERR_LO;
    #1;
    check("midreset_errlo", 32'(data_out), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_sample("debounce_after_reset", 16'o055555, 16'h0000, 0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
